// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative HI/LO multiply/divide unit (shift-add / restoring divide)
module muldiv_unit #(
  parameter int WIDTH     = 32,
  parameter int FIX_CYCLE = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int CW     = $clog2(WIDTH + 1);
  localparam bit FIX_EN = (FIX_CYCLE != 0);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t             r_state, w_next;
  logic [1:0]         r_op;
  logic [WIDTH-1:0]   r_a, r_b, r_opnd, r_hi, r_lo;
  logic [2*WIDTH-1:0] r_prod;
  logic [CW-1:0]      r_cnt;
  logic               r_dz, r_done, r_div_zero;

  logic               w_write, w_accept, w_is_md, w_is_div_in, w_in_dz;
  logic               w_is_div, w_signed, w_last, w_ge;
  logic [WIDTH-1:0]   w_abs_a, w_abs_b, w_diff, w_quo, w_rem, w_hi_res, w_lo_res;
  logic [WIDTH:0]     w_madd, w_rem_sh;
  logic [2*WIDTH-1:0] w_mul_next, w_div_next, w_iter, w_src, w_prod_res;

  assign w_accept    = start && (r_state == S_IDLE);
  assign w_is_md     = (op[2] == 1'b0);
  assign w_is_div_in = (op[2:1] == 2'b01);
  assign w_in_dz     = w_is_div_in && (b == '0);

  assign w_is_div = r_op[1];
  assign w_signed = ~r_op[0];
  assign w_last   = (r_cnt == CW'(WIDTH));

  assign w_abs_a = (w_signed && r_a[WIDTH-1]) ? -r_a : r_a;
  assign w_abs_b = (w_signed && r_b[WIDTH-1]) ? -r_b : r_b;

  // Multiply: add multiplicand into the upper half when the LSB is set, then shift right.
  assign w_madd     = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + {1'b0, r_opnd};
  assign w_mul_next = r_prod[0] ? {w_madd, r_prod[WIDTH-1:1]}
                                : {1'b0, r_prod[2*WIDTH-1:1]};

  // Divide: upper half is the partial remainder, lower half shifts dividend out / quotient in.
  assign w_rem_sh   = r_prod[2*WIDTH-1:WIDTH-1];
  assign w_ge       = (w_rem_sh >= {1'b0, r_opnd});
  assign w_diff     = w_rem_sh[WIDTH-1:0] - r_opnd;
  assign w_div_next = w_ge ? {w_diff, r_prod[WIDTH-2:0], 1'b1}
                           : {r_prod[2*WIDTH-2:0], 1'b0};

  assign w_iter = w_is_div ? w_div_next : w_mul_next;
  assign w_src  = (r_state == S_FIX) ? r_prod : w_iter;

  assign w_prod_res = (w_signed && (r_a[WIDTH-1] ^ r_b[WIDTH-1])) ? -w_src : w_src;
  assign w_quo      = (w_signed && (r_a[WIDTH-1] ^ r_b[WIDTH-1])) ? -w_src[WIDTH-1:0]
                                                                  : w_src[WIDTH-1:0];
  assign w_rem      = (w_signed && r_a[WIDTH-1]) ? -w_src[2*WIDTH-1:WIDTH]
                                                 : w_src[2*WIDTH-1:WIDTH];
  assign w_hi_res   = w_is_div ? w_rem : w_prod_res[2*WIDTH-1:WIDTH];
  assign w_lo_res   = w_is_div ? w_quo : w_prod_res[WIDTH-1:0];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_write = 1'b0;
    case (r_state)
      S_IDLE: if (start && w_is_md) w_next = w_in_dz ? S_FIX : S_CALC;
      S_CALC: begin
        if (cancel) begin
          w_next = S_IDLE;
        end else if (w_last) begin
          if (FIX_EN) begin
            w_next = S_FIX;
          end else begin
            w_next  = S_IDLE;
            w_write = 1'b1;
          end
        end
      end
      S_FIX: begin
        w_next  = S_IDLE;
        w_write = !cancel;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // CALC step 0 loads magnitudes; steps 1..WIDTH are the iterations.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_op       <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_opnd     <= '0;
      r_prod     <= '0;
      r_cnt      <= '0;
      r_dz       <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        if (op == 3'b100) begin
          r_hi <= a;
        end else if (op == 3'b101) begin
          r_lo <= a;
        end else if (w_is_md) begin
          r_a   <= a;
          r_b   <= b;
          r_op  <= op[1:0];
          r_cnt <= '0;
          r_dz  <= w_in_dz;
          if (w_is_div_in && !w_in_dz) r_div_zero <= 1'b0;
        end
      end else if (r_state == S_CALC && !cancel) begin
        r_cnt <= r_cnt + CW'(1);
        if (r_cnt == '0) begin
          r_opnd <= w_is_div ? w_abs_b : w_abs_a;
          r_prod <= {{WIDTH{1'b0}}, (w_is_div ? w_abs_a : w_abs_b)};
        end else begin
          r_prod <= w_iter;
        end
      end
      if (w_write) begin
        r_done <= 1'b1;
        if (r_dz) begin
          r_hi       <= r_a;
          r_lo       <= '1;
          r_div_zero <= 1'b1;
        end else begin
          r_hi <= w_hi_res;
          r_lo <= w_lo_res;
        end
      end
    end
  end

  assign busy     = (r_state != S_IDLE);
  assign done     = r_done;
  assign hi       = r_hi;
  assign lo       = r_lo;
  assign div_zero = r_div_zero;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - scoreboard bench for muldiv_unit against an arithmetic reference model
module tb_muldiv_unit;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic         cancel = 1'b0;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic        m_dz = 1'b0;

  muldiv_unit #(.WIDTH(W), .FIX_CYCLE(1)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .cancel   (cancel),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo),
    .div_zero (div_zero)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  always @(negedge clock) begin
    if (reset_n === 1'b1 && done === 1'b1) begin
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
      end else begin
        mon_e = q.pop_front();
        check("done_cycle", 64'(cyc), 64'(mon_e.cyc));
        check("hi", hi, mon_e.hi);
        check("lo", lo, mon_e.lo);
        check("div_zero", div_zero, mon_e.dz);
      end
    end
  end

  task automatic wait_idle();
    int t = 0;
    while (busy !== 1'b0 && t < 100) begin
      @(negedge clock);
      t++;
    end
    if (busy !== 1'b0) begin
      n_tests++;
      n_fail++;
      $display("FAIL idle_timeout: got busy=%b expected 0", busy);
    end
  endtask

  task automatic issue(input logic [2:0] op_i, input logic [31:0] a_i, input logic [31:0] b_i,
                       input bit push, input bit with_cancel);
    exp_t        e;
    bit          md;
    longint      sa, sb, sq, sr;
    logic [63:0] p;
    wait_idle();
    md   = (op_i <= 3'd3);
    e.hi = m_hi;
    e.lo = m_lo;
    e.dz = m_dz;
    e.cyc = cyc + 1 + ((op_i[1] && b_i == 32'd0) ? 1 : W + 2);
    sa = longint'($signed(a_i));
    sb = longint'($signed(b_i));
    case (op_i)
      3'd0: begin p = sa * sb; e.hi = p[63:32]; e.lo = p[31:0]; end
      3'd1: begin p = {32'd0, a_i} * {32'd0, b_i}; e.hi = p[63:32]; e.lo = p[31:0]; end
      3'd2, 3'd3: begin
        if (b_i == 32'd0) begin
          e.hi = a_i;
          e.lo = 32'hFFFF_FFFF;
          e.dz = 1'b1;
        end else if (op_i == 3'd2) begin
          sq = sa / sb;
          sr = sa % sb;
          e.lo = sq[31:0];
          e.hi = sr[31:0];
          e.dz = 1'b0;
        end else begin
          e.lo = a_i / b_i;
          e.hi = a_i % b_i;
          e.dz = 1'b0;
        end
      end
      3'd4: e.hi = a_i;
      3'd5: e.lo = a_i;
      default: ;
    endcase
    start  = 1'b1;
    op     = op_i;
    a      = a_i;
    b      = b_i;
    cancel = with_cancel;
    @(negedge clock);
    start  = 1'b0;
    cancel = 1'b0;
    if (push) begin
      m_hi = e.hi;
      m_lo = e.lo;
      m_dz = e.dz;
      if (md) q.push_back(e);
    end
    if (md) begin
      check("busy_after_accept", busy, 1);
    end else begin
      check("busy_after_idle_op", busy, 0);
      check("hi_after_idle_op", hi, m_hi);
      check("lo_after_idle_op", lo, m_lo);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clock);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_hi", hi, 0);
    check("reset_lo", lo, 0);
    check("reset_div_zero", div_zero, 0);

    reset_n = 1'b1;
    issue(3'd0, 32'hFFFF_FFFD, 32'h0000_0005, 1, 0);
    wait_idle();
    check("mult_neg_hi", hi, 32'hFFFF_FFFF);
    check("mult_neg_lo", lo, 32'hFFFF_FFF1);

    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0);
    repeat (4) @(negedge clock);
    start = 1'b1; op = 3'd4; a = 32'hDEAD_BEEF;
    @(negedge clock);
    start = 1'b0;
    wait_idle();
    check("multu_max_hi", hi, 32'hFFFF_FFFE);
    check("multu_max_lo", lo, 32'h0000_0001);

    issue(3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 1, 0);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1, 0);
    wait_idle();
    check("div_ovf_lo", lo, 32'h8000_0000);
    check("div_ovf_hi", hi, 32'h0000_0000);

    issue(3'd3, 32'h0000_0007, 32'h0000_0000, 1, 0);
    wait_idle();
    check("divz_flag", div_zero, 1);
    issue(3'd3, 32'h0000_0009, 32'h0000_0004, 1, 0);
    wait_idle();
    check("divu_lo", lo, 32'h0000_0002);
    check("divu_hi", hi, 32'h0000_0001);
    check("divz_cleared", div_zero, 0);

    issue(3'd4, 32'h1234_5678, 32'h0, 1, 0);
    issue(3'd1, 32'h0000_0003, 32'h0000_0003, 0, 0);
    repeat (9) @(negedge clock);
    cancel = 1'b1;
    @(negedge clock);
    cancel = 1'b0;
    check("cancel_busy", busy, 0);
    check("cancel_hi", hi, 32'h1234_5678);
    repeat (40) @(negedge clock);
    check("cancel_hi_held", hi, 32'h1234_5678);
    check("cancel_lo_held", lo, m_lo);

    issue(3'd0, 32'h0000_0007, 32'hFFFF_FFFE, 1, 1);

    for (int i = 0; i < 50; i++) begin
      issue(3'($urandom_range(0, 7)), pick(), pick(), 1, ($urandom_range(0, 3) == 0));
    end
    wait_idle();

    issue(3'd2, 32'h0000_1234, 32'h0000_0003, 0, 0);
    repeat (4) @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_hi", hi, 0);
    check("arst_lo", lo, 0);
    check("arst_div_zero", div_zero, 0);
    m_hi = '0;
    m_lo = '0;
    m_dz = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    issue(3'd0, 32'h0001_0003, 32'hFFFF_0005, 1, 0);
    wait_idle();
    repeat (3) @(negedge clock);
    check("queue_empty", 64'(q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
